// File: rtl/boost_ctrl_multiphase.sv
// boost_ctrl_multiphase: N-phase interleaved peak-current-mode hysteretic boost controller
// with current-offset calibration and latched over-voltage fault.
module boost_ctrl_multiphase #(
  parameter int N_PH        = 2,
  parameter int IL_W        = 10,
  parameter int V_W         = 12,
  parameter int CNT_W       = 24,
  parameter int BLANK_TIME  = 100,
  parameter int OFF_TIME    = 2000,
  parameter int ON_TIME_MAX = 20000,
  parameter int CAL_LOG2    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PH*IL_W-1:0] il_adc_i,
  input  logic [V_W-1:0]       vout_adc_i,
  input  logic [V_W-1:0]       vout_target_i,
  input  logic [V_W-1:0]       vout_delta_i,
  input  logic [V_W-1:0]       ovp_level_i,
  input  logic [IL_W-1:0]      i_limit_i,
  input  logic                 boost_init_i,
  input  logic                 boost_en_i,
  input  logic                 fault_clr_i,
  output logic [N_PH-1:0]      sw_out_o,
  output logic                 cal_done_o,
  output logic                 running_o,
  output logic                 fault_ovp_o,
  output logic [N_PH-1:0]      ontime_flag_o
);
  localparam int TW = N_PH > 1 ? $clog2(N_PH) : 1;
  localparam int AW = IL_W + CAL_LOG2;
  localparam int CW = CAL_LOG2 + 3;

  typedef enum logic [2:0] {CAL_WAIT, CAL, IDLE, RUN, FAULT} top_e;
  typedef enum logic [1:0] {P_IDLE, P_ON_BLANK, P_RAMPUP, P_RAMPDOWN} ph_e;

  top_e             top_q, top_d;
  logic [CW-1:0]    cal_cnt_q, cal_cnt_d;
  logic [AW-1:0]    acc_q [N_PH];
  logic [AW-1:0]    acc_d [N_PH];
  logic [IL_W-1:0]  null_q [N_PH];
  logic [IL_W-1:0]  null_d [N_PH];
  ph_e              ph_q [N_PH];
  ph_e              ph_d [N_PH];
  logic [CNT_W-1:0] cnt_q [N_PH];
  logic [CNT_W-1:0] cnt_d [N_PH];
  logic             cal_done_q, cal_done_d, running_q, fault_q, fault_d;
  logic [N_PH-1:0]  flag_q, flag_d, sw_q, sw_d, trip, over;
  logic [TW-1:0]    tok_q, tok_d;
  logic [V_W-1:0]   v_low;
  logic             ovp, allow;

  // Trip compare is one bit wider than the ADC so null + limit cannot wrap.
  for (genvar i = 0; i < N_PH; i++) begin : g_ph
    assign trip[i] = {1'b0, il_adc_i[i*IL_W +: IL_W]} > ({1'b0, null_q[i]} + {1'b0, i_limit_i});
    assign over[i] = cnt_q[i] > CNT_W'(ON_TIME_MAX);
  end

  assign v_low = vout_target_i > vout_delta_i ? vout_target_i - vout_delta_i : '0;
  assign ovp   = (top_q == IDLE || top_q == RUN || top_q == FAULT) && vout_adc_i > ovp_level_i;
  assign allow = top_q == RUN && !ovp && boost_en_i && !(vout_adc_i > vout_target_i);

  always_comb begin
    top_d      = top_q;
    cal_cnt_d  = cal_cnt_q;
    acc_d      = acc_q;
    null_d     = null_q;
    cal_done_d = cal_done_q;
    fault_d    = fault_q;
    flag_d     = flag_q;
    tok_d      = tok_q;
    ph_d       = ph_q;
    cnt_d      = cnt_q;
    sw_d       = '0;
    case (top_q)
      CAL_WAIT: if (boost_init_i) begin
        top_d     = CAL;
        cal_cnt_d = '0;
        for (int k = 0; k < N_PH; k++) acc_d[k] = '0;
      end
      CAL: if (cal_cnt_q[CW-1]) begin
        for (int k = 0; k < N_PH; k++) null_d[k] = acc_q[k][AW-1:CAL_LOG2];
        cal_done_d = 1'b1;
        top_d      = IDLE;
      end else begin
        cal_cnt_d = cal_cnt_q + CW'(1);
        if (cal_cnt_q[1:0] == 2'b00)
          for (int k = 0; k < N_PH; k++) acc_d[k] = acc_q[k] + AW'(il_adc_i[k*IL_W +: IL_W]);
      end
      IDLE:  top_d = boost_en_i && vout_adc_i < v_low ? RUN : IDLE;
      RUN:   top_d = vout_adc_i > vout_target_i || !boost_en_i ? IDLE : RUN;
      FAULT: if (fault_clr_i && !boost_en_i && !ovp) begin
        top_d   = IDLE;
        fault_d = 1'b0;
        flag_d  = '0;
      end
      default: top_d = CAL_WAIT;
    endcase
    if (ovp) begin
      top_d   = FAULT;
      fault_d = 1'b1;
    end
    for (int k = 0; k < N_PH; k++) begin
      case (ph_q[k])
        P_IDLE: if (allow && tok_q == TW'(k)) begin
          ph_d[k]  = P_ON_BLANK;
          cnt_d[k] = '0;
          tok_d    = tok_q == TW'(N_PH - 1) ? '0 : tok_q + TW'(1);
        end
        P_ON_BLANK: begin
          ph_d[k]  = cnt_q[k] == CNT_W'(BLANK_TIME - 1) ? P_RAMPUP : P_ON_BLANK;
          cnt_d[k] = cnt_q[k] == CNT_W'(BLANK_TIME - 1) ? '0 : cnt_q[k] + CNT_W'(1);
        end
        P_RAMPUP: begin
          ph_d[k]  = trip[k] || over[k] ? P_RAMPDOWN : P_RAMPUP;
          cnt_d[k] = trip[k] || over[k] ? '0 : cnt_q[k] + CNT_W'(1);
          if (over[k]) flag_d[k] = 1'b1;
        end
        P_RAMPDOWN: begin
          ph_d[k]  = cnt_q[k] == CNT_W'(OFF_TIME) ? P_IDLE : P_RAMPDOWN;
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
        default: ph_d[k] = P_IDLE;
      endcase
      if (ovp) begin
        ph_d[k]  = P_IDLE;
        cnt_d[k] = '0;
      end
      sw_d[k] = ph_d[k] == P_ON_BLANK || ph_d[k] == P_RAMPUP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q      <= CAL_WAIT;
      cal_cnt_q  <= '0;
      cal_done_q <= 1'b0;
      running_q  <= 1'b0;
      fault_q    <= 1'b0;
      flag_q     <= '0;
      sw_q       <= '0;
      tok_q      <= '0;
      for (int k = 0; k < N_PH; k++) begin
        acc_q[k]  <= '0;
        null_q[k] <= '0;
        ph_q[k]   <= P_IDLE;
        cnt_q[k]  <= '0;
      end
    end else begin
      top_q      <= top_d;
      cal_cnt_q  <= cal_cnt_d;
      cal_done_q <= cal_done_d;
      running_q  <= top_d == RUN;
      fault_q    <= fault_d;
      flag_q     <= flag_d;
      sw_q       <= sw_d;
      tok_q      <= tok_d;
      acc_q      <= acc_d;
      null_q     <= null_d;
      ph_q       <= ph_d;
      cnt_q      <= cnt_d;
    end
  end

  assign sw_out_o      = sw_q;
  assign cal_done_o    = cal_done_q;
  assign running_o     = running_q;
  assign fault_ovp_o   = fault_q;
  assign ontime_flag_o = flag_q;
endmodule

// File: tb/tb_boost_ctrl_multiphase.sv
// tb_boost_ctrl_multiphase: randomized scoreboard bench; a cycle-level behavioural model
// pushes expected outputs per clock and a negedge monitor pops and compares them.
module tb_boost_ctrl_multiphase;
  localparam int N = 2, ILW = 10, VW = 12, CW = 16, BT = 4, OT = 12, OM = 40, CL = 10;

  logic              clk = 1'b0, rst = 1'b1;
  logic [N*ILW-1:0]  il;
  logic [VW-1:0]     vout, tgt, dlt, ovl;
  logic [ILW-1:0]    ilim;
  logic              init, en, clr;
  logic [N-1:0]      sw, flag;
  logic              cal_done, running, fault;

  boost_ctrl_multiphase #(
    .N_PH(N), .IL_W(ILW), .V_W(VW), .CNT_W(CW), .BLANK_TIME(BT),
    .OFF_TIME(OT), .ON_TIME_MAX(OM), .CAL_LOG2(CL)
  ) dut (
    .clk(clk), .rst(rst), .il_adc_i(il), .vout_adc_i(vout), .vout_target_i(tgt),
    .vout_delta_i(dlt), .ovp_level_i(ovl), .i_limit_i(ilim), .boost_init_i(init),
    .boost_en_i(en), .fault_clr_i(clr), .sw_out_o(sw), .cal_done_o(cal_done),
    .running_o(running), .fault_ovp_o(fault), .ontime_flag_o(flag)
  );

  always #5 clk = ~clk;

  typedef logic [2*N+2:0] exp_t;
  exp_t exq[$];
  exp_t me, ma;
  int n_run = 0, n_fail = 0;

  // Reference model: top mode 0 wait,1 cal,2 idle,3 run,4 fault; phase mode 0 idle,1 on,2 off,
  // t = cycles spent in the current phase mode.
  int top, cal_n, tok, tk, lo_thr, ilv;
  int acc[N], nul[N], mode[N], t[N];
  bit calq, flt, ovp, allow;
  bit [N-1:0] fl, swm;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      top = 0; cal_n = 0; tok = 0; calq = 0; flt = 0; fl = '0;
      for (int k = 0; k < N; k++) begin acc[k] = 0; nul[k] = 0; mode[k] = 0; t[k] = 0; end
      exq.delete();
    end else begin
      ovp    = top >= 2 && vout > ovl;
      allow  = top == 3 && !ovp && en && vout <= tgt;
      lo_thr = tgt > dlt ? int'(tgt) - int'(dlt) : 0;
      tk     = tok;
      for (int k = 0; k < N; k++) begin
        ilv = il[k*ILW +: ILW];
        if (ovp) begin mode[k] = 0; t[k] = 0; end
        else if (mode[k] == 0) begin
          if (allow && tk == k) begin mode[k] = 1; t[k] = 0; tok = (tok + 1) % N; end
        end else if (mode[k] == 1) begin
          if (t[k] < BT) t[k]++;
          else if (ilv > nul[k] + ilim || t[k] - BT > OM) begin
            if (t[k] - BT > OM) fl[k] = 1'b1;
            mode[k] = 2; t[k] = 0;
          end else t[k]++;
        end else begin
          if (t[k] == OT) begin mode[k] = 0; t[k] = 0; end else t[k]++;
        end
      end
      case (top)
        0: if (init) begin
          top = 1; cal_n = 0;
          for (int k = 0; k < N; k++) acc[k] = 0;
        end
        1: if (cal_n == 4 << CL) begin
          for (int k = 0; k < N; k++) nul[k] = acc[k] >> CL;
          calq = 1; top = 2;
        end else begin
          if (cal_n % 4 == 0) for (int k = 0; k < N; k++) acc[k] += il[k*ILW +: ILW];
          cal_n++;
        end
        2: if (en && vout < lo_thr) top = 3;
        3: if (vout > tgt || !en) top = 2;
        4: if (clr && !en && !ovp) begin top = 2; flt = 0; fl = '0; end
        default: ;
      endcase
      if (ovp) begin top = 4; flt = 1; end
    end
    for (int k = 0; k < N; k++) swm[k] = mode[k] == 1;
    exq.push_back({swm, calq, top == 3, flt, fl});
  end

  always @(negedge clk) begin
    if (exq.size() > 0) begin
      me = exq.pop_front();
      ma = {sw, cal_done, running, fault, flag};
      n_run++;
      if (ma !== me) begin
        n_fail++;
        if (n_fail <= 30)
          $display("FAIL outputs(sw|cal|run|ovp|flag) t=%0t got %b want %b", $time, ma, me);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_il(input int lo, input int hi);
    for (int k = 0; k < N; k++) il[k*ILW +: ILW] = ILW'($urandom_range(hi, lo));
  endtask

  task automatic rand_run(input int cycles, input int ilo, input int ihi);
    int r;
    repeat (cycles) begin
      rand_il(ilo, ihi);
      if ($urandom_range(40, 0) == 0) en = ~en;
      r    = $urandom_range(99, 0);
      vout = r < 2 ? VW'($urandom_range(505, 501)) : r < 50 ? VW'($urandom_range(432, 420)) : VW'($urandom_range(445, 430));
      clr  = $urandom_range(30, 0) == 0;
      step(1);
    end
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; il = {N{10'd512}}; vout = '0; tgt = 12'd440; dlt = 12'd10; ovl = 12'd500;
    ilim = 10'd40; init = 1'b0; en = 1'b0; clr = 1'b0;
    step(3); rst = 1'b0; step(5);
    init = 1'b1; step(1); init = 1'b0;
    step(4200);
    init = 1'b1; step(2); init = 1'b0;
    en = 1'b1; vout = 12'd430; step(20);
    vout = 12'd429; step(1);
    repeat (300) begin rand_il(530, 565); vout = VW'($urandom_range(440, 425)); step(1); end
    vout = 12'd441; step(1);
    vout = 12'd435; il = {N{10'd512}}; step(40);
    vout = 12'd425; step(150);
    vout = 12'd435; step(40);
    vout = 12'd425; step(BT + 8);
    vout = 12'd501; step(3);
    vout = 12'd450; clr = 1'b1; step(1); clr = 1'b0; step(3);
    en = 1'b0; clr = 1'b1; step(1); clr = 1'b0; step(3);
    en = 1'b1;
    rand_run(3000, 505, 570);
    en = 1'b1; vout = 12'd420; clr = 1'b1; step(1); clr = 1'b0;
    en = 1'b0; clr = 1'b1; step(1); clr = 1'b0; en = 1'b1;
    il = {N{10'd512}}; step(BT + 6);
    @(posedge clk); #2 rst = 1'b1; #1;
    n_run++;
    if (sw !== '0 || cal_done !== 1'b0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got sw=%b cal=%b run=%b want sw=0 cal=0 run=0", sw, cal_done, running);
    end
    step(2); rst = 1'b0; en = 1'b0; step(3);
    init = 1'b1; step(1); init = 1'b0;
    repeat (4200) begin rand_il(480, 540); step(1); end
    en = 1'b1;
    rand_run(1500, 490, 580);
    step(2);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/boost_ctrl_multiphase.md
# boost_ctrl_multiphase

Multi-phase, peak-current-mode, hysteretic boost controller: the parametrised successor to the single-phase boost state machine. It sits between the high-speed inductor-current ADC / XADC voltage samples and the gate-drive pins. It drives N_PH interleaved phases from one shared output-voltage loop. The block adds runtime-programmable setpoints, per-phase current-offset calibration, round-robin phase interleaving, and a latched over-voltage fault.

## Interface
- N_PH, 2: number of phases (1..8)
- IL_W, 10: inductor-current ADC width (unsigned, mid-scale offset)
- V_W, 12: voltage ADC width
- CNT_W, 24: timing counter width
- BLANK_TIME, 100: leading-edge blanking, cycles
- OFF_TIME, 2000: fixed switch-off time, cycles
- ON_TIME_MAX, 20000: maximum on-time, cycles
- CAL_LOG2, 10: log2 of calibration sample count
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- il_adc  in  N_PH*IL_W  per-phase current samples; phase k is bits [k*IL_W +: IL_W]
- vout_adc  in  V_W  output voltage sample
- vout_target  in  V_W  regulation upper threshold
- vout_delta  in  V_W  hysteresis width
- ovp_level  in  V_W  over-voltage trip threshold
- i_limit  in  IL_W  peak current above calibrated null
- boost_init  in  1  start calibration (level)
- boost_en  in  1  run enable
- fault_clr  in  1  clear latched fault (pulse)
- sw_out  out  N_PH  gate drive, registered
- cal_done  out  1  calibration complete
- running  out  1  top FSM in RUN
- fault_ovp  out  1  latched over-voltage fault
- ontime_flag  out  N_PH  sticky: phase hit ON_TIME_MAX

## Operation
- Top FSM states: CAL_WAIT, CAL, IDLE, RUN, FAULT. Reset enters CAL_WAIT.
- CAL_WAIT: boost_init=1 → CAL, and clear the counter and accumulators.
- CAL: the counter increments every cycle. On counter[1:0]==0, each phase accumulator adds its il_adc. When the sample count reaches 2^CAL_LOG2, null_k = acc_k >> CAL_LOG2, cal_done=1, → IDLE.
- Accumulator width is IL_W+CAL_LOG2 (no overflow).
- IDLE: boost_en=1 and vout_adc < vout_target − vout_delta → RUN. The subtraction saturates at 0.
- Per-phase FSM: P_IDLE, P_ON_BLANK, P_RAMPUP, P_RAMPDOWN; each phase has its own CNT_W counter.
- Round-robin token selects a phase. In RUN, if the token phase is in P_IDLE, it starts: sw_out[k]=1, → P_ON_BLANK, and the token advances (mod N_PH).
- Only one phase starts per cycle.
- P_ON_BLANK: after BLANK_TIME cycles → P_RAMPUP. Current is ignored during blanking.
- P_RAMPUP turns the switch off (sw_out[k]=0, → P_RAMPDOWN) on either condition:
  - il_k > null_k + i_limit, computed at IL_W+1 bits unsigned;
  - the counter exceeds ON_TIME_MAX; this also sets ontime_flag[k].
  - If both are true in the same cycle, the switch turns off once and the flag is still set.
- P_RAMPDOWN: after OFF_TIME cycles → P_IDLE.
- RUN → IDLE when vout_adc > vout_target or boost_en=0. Phases in progress finish their cycle normally. No new starts occur, and no new starts occur in IDLE.
- Over-voltage: vout_adc > ovp_level in any state except CAL_WAIT/CAL triggers all of the following:
  - top → FAULT;
  - fault_ovp=1;
  - all phase FSMs forced to P_IDLE;
  - sw_out=0 on the next edge.
- FAULT: leaves only on fault_clr=1 with boost_en=0 → IDLE. fault_clr also clears ontime_flag. fault_clr while boost_en=1 is ignored.
- boost_init is ignored outside CAL_WAIT. Recalibration requires rst.

## Timing
- Reset values: sw_out=0, cal_done=0, running=0, fault_ovp=0, ontime_flag=0, all null/accumulator/counter registers 0, token=0.
- Reset is honoured mid-switching: sw_out drops asynchronously.
- sw_out rises 1 cycle after the start decision; the start decision is made in the cycle after RUN is entered.
- Current-trip latency: sw_out falls on the clock edge following the first cycle with il_k above threshold (1 cycle).
- OVP latency: 1 cycle from vout_adc sample to sw_out=0 and fault_ovp=1.
- Minimum switching period per phase: BLANK_TIME + 1 + OFF_TIME + 2 cycles.
- Phase starts are at least 1 cycle apart. The natural stagger comes from token order.
- running mirrors top-state RUN, registered.

## Test plan
- Calibration: il_adc all phases = 512 constant, boost_init pulse → cal_done after 4·1024 cycles; in RUN with i_limit=40, trip occurs at il=553, not at 552.
- Hysteresis: vout_target=440, delta=10, boost_en=1 → no start at vout=430, start at 429; RUN exits when vout=441; in-flight phase completes OFF_TIME.
- Interleave: N_PH=2, il ramps to limit → sw_out[0] rises before sw_out[1], never both in the same cycle; order 0,1,0,1.
- On-time max: il held at null → sw_out[k] high for BLANK_TIME+ON_TIME_MAX+~2 cycles, ontime_flag[k]=1.
- OVP: ovp_level=500, vout steps to 501 mid-RAMPUP → sw_out=0 next cycle, fault_ovp=1; fault_clr with boost_en=1 ignored; with boost_en=0 → IDLE, fault_ovp=0.
- Async reset asserted mid-RAMPUP → sw_out=0 immediately, top returns to CAL_WAIT, cal_done=0.
